// File: rtl/cmu_result_collector.sv
// Collects one 64-bit result per CMU lane per round and presents the full round
// to the covariance writer over a valid/ready handshake; flags overruns and stalls.
module cmu_result_collector #(
  parameter int DBL_WIDTH      = 64,
  parameter int N_LANES        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic [N_LANES-1:0]             in_valid,
  input  logic [N_LANES*DBL_WIDTH-1:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_LANES*DBL_WIDTH-1:0]   out_data,
  output logic [CNT_WIDTH-1:0]           overrun_cnt,
  output logic                           timeout
);

  localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]      TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [N_LANES-1:0] ALL  = '1;

  typedef enum logic {S_COLLECT, S_HOLD} state_t;

  state_t             state, state_nxt;
  logic [N_LANES-1:0] got, got_nxt, cap;
  logic [TW-1:0]      timer, timer_nxt;
  logic               drop;
  logic               timeout_set;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Next state, per-lane capture enables, drop detection and stall timer
  always_comb begin
    state_nxt   = state;
    got_nxt     = got;
    cap         = '0;
    drop        = 1'b0;
    timer_nxt   = '0;
    timeout_set = 1'b0;
    case (state)
      S_COLLECT: begin
        cap     = in_valid & ~got;
        drop    = |(in_valid & got);
        got_nxt = got | in_valid;
        if (got_nxt == ALL) begin
          state_nxt = S_HOLD;
        end else if (got != '0) begin
          // Timer holds at its terminal value so a long stall cannot wrap it
          timer_nxt   = (timer == TMAX) ? timer : timer + TW'(1);
          timeout_set = (timer == TMAX);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          // Pulses arriving at the handshake seed the next round
          cap       = in_valid;
          got_nxt   = in_valid;
          state_nxt = (in_valid == ALL) ? S_HOLD : S_COLLECT;
        end else begin
          drop = |in_valid;
        end
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_COLLECT;
      got         <= '0;
      timer       <= '0;
      overrun_cnt <= '0;
      timeout     <= 1'b0;
    end else if (clear) begin
      state       <= S_COLLECT;
      got         <= '0;
      timer       <= '0;
      overrun_cnt <= '0;
      timeout     <= 1'b0;
    end else begin
      state <= state_nxt;
      got   <= got_nxt;
      timer <= timer_nxt;
      if (drop)        overrun_cnt <= sat_inc(overrun_cnt);
      if (timeout_set) timeout     <= 1'b1;
    end
  end

  // Lane data is copied bit-exact; a clear cycle captures nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (!clear) begin
      for (int i = 0; i < N_LANES; i++) begin
        if (cap[i]) out_data[i*DBL_WIDTH +: DBL_WIDTH] <= in_data[i*DBL_WIDTH +: DBL_WIDTH];
      end
    end
  end

  assign out_valid = (state == S_HOLD);

endmodule
